// File: rtl/camera_capture.sv
// Camera byte-stream capture: pairs RGB444 bytes into pixels and drives the image buffer write port.
// Optional frame/line statistics are enabled with the CAPTURE_STATS_EN macro.
module camera_capture #(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned PIX_W  = 12
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        cam_data,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [PIX_W-1:0]  data_out,
  output logic              frame_start,
  output logic              frame_end,
`ifdef CAPTURE_STATS_EN
  output logic [15:0]       frame_count,
  output logic              line_err,
`endif
  output logic              overrun
);

  localparam int unsigned FRAME_PIX = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic start_c, end_c, accept_c;

  logic              phase_q, phase_d;
  logic [3:0]        byte0_lo_q, byte0_lo_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wraddress_q, wraddress_d;
  logic [PIX_W-1:0]  data_out_q, data_out_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic              overrun_q, overrun_d;

  // FSM state register
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a frame opens only on a vsync fall seen from SYNC
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (vsync)  state_d = SYNC;
      SYNC:    if (!vsync) state_d = CAPTURE;
      CAPTURE: if (vsync)  state_d = SYNC;
      default:             state_d = IDLE;
    endcase
  end

  // FSM decoded strobes
  always_comb begin
    start_c  = 1'b0;
    end_c    = 1'b0;
    accept_c = 1'b0;
    if (state_q == SYNC && !vsync)   start_c  = 1'b1;
    if (state_q == CAPTURE) begin
      end_c    = vsync;
      accept_c = !vsync && href;
    end
  end

  // Byte pairing and write-port generation; the counter is the linear address
  always_comb begin
    phase_d       = 1'b0;
    byte0_lo_d    = byte0_lo_q;
    cnt_d         = cnt_q;
    wren_d        = 1'b0;
    wraddress_d   = wraddress_q;
    data_out_d    = data_out_q;
    overrun_d     = overrun_q;
    frame_start_d = start_c;
    frame_end_d   = end_c;
    if (start_c) begin
      cnt_d     = '0;
      overrun_d = 1'b0;
    end
    if (accept_c) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        byte0_lo_d = cam_data[3:0];
      end else if (cnt_q == ADDR_W'(FRAME_PIX)) begin
        overrun_d = 1'b1;
      end else begin
        wren_d      = 1'b1;
        wraddress_d = cnt_q;
        data_out_d  = PIX_W'({byte0_lo_q, cam_data});
        cnt_d       = cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= 1'b0;
      byte0_lo_q    <= '0;
      cnt_q         <= '0;
      wren_q        <= 1'b0;
      wraddress_q   <= '0;
      data_out_q    <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      byte0_lo_q    <= byte0_lo_d;
      cnt_q         <= cnt_d;
      wren_q        <= wren_d;
      wraddress_q   <= wraddress_d;
      data_out_q    <= data_out_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      overrun_q     <= overrun_d;
    end
  end

  assign wren        = wren_q;
  assign wraddress   = wraddress_q;
  assign data_out    = data_out_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign overrun     = overrun_q;

`ifdef CAPTURE_STATS_EN
  localparam int unsigned LINE_BYTES = 2 * IMG_W;
  localparam int unsigned LB_W       = $clog2(LINE_BYTES + 2);

  logic            href_q, href_d;
  logic [LB_W-1:0] lb_cnt_q, lb_cnt_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic            line_err_q, line_err_d;
  logic            line_end_c;

  // Per-line byte count checked at each href fall; the counter saturates
  always_comb begin
    href_d        = href;
    lb_cnt_d      = lb_cnt_q;
    frame_count_d = frame_count_q;
    line_err_d    = line_err_q;
    line_end_c    = (state_q == CAPTURE) && href_q && !href;
    if (end_c) frame_count_d = frame_count_q + 16'd1;
    if (start_c) begin
      lb_cnt_d   = '0;
      line_err_d = 1'b0;
    end else if (line_end_c) begin
      lb_cnt_d = '0;
      if (lb_cnt_q != LB_W'(LINE_BYTES)) line_err_d = 1'b1;
    end else if (accept_c && lb_cnt_q != '1) begin
      lb_cnt_d = lb_cnt_q + LB_W'(1);
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q        <= 1'b0;
      lb_cnt_q      <= '0;
      frame_count_q <= '0;
      line_err_q    <= 1'b0;
    end else begin
      href_q        <= href_d;
      lb_cnt_q      <= lb_cnt_d;
      frame_count_q <= frame_count_d;
      line_err_q    <= line_err_d;
    end
  end

  assign frame_count = frame_count_q;
  assign line_err    = line_err_q;
`endif

endmodule

// File: tb/tb_camera_capture.sv
// Randomized bench for camera_capture with a frame-level reference model (reduced image size).
module tb_camera_capture;

  localparam int unsigned IMG_W  = 16;
  localparam int unsigned IMG_H  = 6;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned PIX_W  = 12;
  localparam int unsigned FRAME  = IMG_W * IMG_H;

  logic              wr_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vsync = 1'b0;
  logic              href = 1'b0;
  logic [7:0]        cam_data = 8'h00;
  logic              wren;
  logic [ADDR_W-1:0] wraddress;
  logic [PIX_W-1:0]  data_out;
  logic              frame_start, frame_end, overrun;
`ifdef CAPTURE_STATS_EN
  logic [15:0]       frame_count;
  logic              line_err;
`endif

  camera_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .wr_clk      (wr_clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .href        (href),
    .cam_data    (cam_data),
    .wren        (wren),
    .wraddress   (wraddress),
    .data_out    (data_out),
    .frame_start (frame_start),
    .frame_end   (frame_end),
`ifdef CAPTURE_STATS_EN
    .frame_count (frame_count),
    .line_err    (line_err),
`endif
    .overrun     (overrun)
  );

  always #5 wr_clk = ~wr_clk;

  int unsigned cyc = 0;
  always @(posedge wr_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  preset[$];
  wr_t         e;
  int unsigned n_checks = 0, n_err = 0;
  int unsigned pix_idx = 0, exp_fs = 0, exp_fe = 0, fs_seen = 0, fe_seen = 0;
  int unsigned exp_fc = 0, n_since_fs = 0;
  int unsigned last_addr = 0, last_data = 0;
  bit          exp_ovr = 1'b0, exp_lerr = 1'b0;
  int unsigned seen_a[2];
  int unsigned seen_d[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    vsync    = vs;
    href     = hr;
    cam_data = d;
    @(posedge wr_clk);
    #1;
  endtask

  // Reference: every second byte of a line forms a pixel at the next linear address until the frame is full
  task automatic model_pix(input logic [7:0] b0, input logic [7:0] b1, input int unsigned c);
    wr_t w;
    if (pix_idx < FRAME) begin
      w.cyc  = c + 1;
      w.addr = pix_idx;
      w.data = {20'd0, b0[3:0], b1};
      exp_q.push_back(w);
      pix_idx++;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic send_bytes(input int unsigned n);
    logic [7:0]  d, b0;
    int unsigned c;
    b0 = 8'h00;
    for (int unsigned i = 0; i < n; i++) begin
      d = (preset.size() != 0) ? preset.pop_front() : 8'($urandom);
      c = cyc;
      drive(1'b0, 1'b1, d);
      if (i % 2 == 0) b0 = d;
      else            model_pix(b0, d, c);
    end
  endtask

  task automatic send_line(input int unsigned n);
    send_bytes(n);
    if (n != 2 * IMG_W) exp_lerr = 1'b1;
    repeat ($urandom_range(3, 1)) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic start_frame();
    repeat ($urandom_range(4, 2)) drive(1'b1, 1'($urandom), 8'($urandom));
    drive(1'b0, 1'b0, 8'h00);
    pix_idx  = 0;
    exp_ovr  = 1'b0;
    exp_lerr = 1'b0;
    exp_fs++;
    check("fs_pulse", frame_start, 1'b1);
    check("fs_ovr_clear", overrun, 1'b0);
`ifdef CAPTURE_STATS_EN
    check("fs_lerr_clear", line_err, 1'b0);
`endif
    drive(1'b0, 1'b0, 8'h00);
    check("fs_once", frame_start, 1'b0);
  endtask

  task automatic end_frame(input logic hr, input logic [7:0] d);
    drive(1'b1, hr, d);
    exp_fe++;
    exp_fc++;
    check("fe_pulse", frame_end, 1'b1);
    check("fe_ovr", overrun, exp_ovr);
`ifdef CAPTURE_STATS_EN
    check("fe_count", frame_count, exp_fc);
    check("fe_lerr", line_err, exp_lerr);
`endif
    drive(1'b1, 1'b0, 8'h00);
    check("fe_once", frame_end, 1'b0);
  endtask

  // Write-port monitor: every wren must match the next modelled write, otherwise outputs must hold
  always @(negedge wr_clk) begin
    if (frame_start) begin
      fs_seen++;
      n_since_fs = 0;
    end
    if (frame_end) fe_seen++;
    if (wren) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wren", wren, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr", 32'(wraddress), e.addr);
        check("wr_data", 32'(data_out), e.data);
        last_addr = e.addr;
        last_data = e.data;
      end
      if (n_since_fs < 2) begin
        seen_a[n_since_fs] = 32'(wraddress);
        seen_d[n_since_fs] = 32'(data_out);
      end
      n_since_fs++;
    end else begin
      check("hold_addr", 32'(wraddress), last_addr);
      check("hold_data", 32'(data_out), last_data);
    end
  end

  initial begin
    // Reset held while a line is already streaming
    repeat (3) drive(1'b0, 1'b1, 8'($urandom));
    check("rst_wren", wren, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    check("rst_fe", frame_end, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) drive(1'b0, (i % 7) != 6, 8'($urandom));

    // Frame A: known first pixels, one odd-length line
    start_frame();
    preset.push_back(8'h0A); preset.push_back(8'hBC);
    preset.push_back(8'h05); preset.push_back(8'h67);
    for (int unsigned l = 0; l < IMG_H; l++) send_line(l == 2 ? 2 * IMG_W + 1 : 2 * IMG_W);
    end_frame(1'b0, 8'h00);
    check("pix0_data", seen_d[0], 32'h0ABC);
    check("pix0_addr", seen_a[0], 32'd0);
    check("pix1_data", seen_d[1], 32'h0567);
    check("pix1_addr", seen_a[1], 32'd1);
    check("frameA_writes", n_since_fs, FRAME);

    // Frame B: one line too many
    start_frame();
    for (int unsigned l = 0; l < IMG_H + 1; l++) send_line(2 * IMG_W);
    end_frame(1'b0, 8'h00);
    check("frameB_writes", n_since_fs, FRAME);
    check("frameB_last_addr", 32'(wraddress), FRAME - 1);
    check("ovr_sticky", overrun, exp_ovr);

    // Frame C: short frame, vsync rises together with an href byte
    start_frame();
    send_line(2 * IMG_W);
    send_bytes(4);
    end_frame(1'b1, 8'($urandom));
    check("frameC_writes", n_since_fs, IMG_W + 2);

    // Frame D: reset asserted right as a write is on the port
    start_frame();
    send_line(2 * IMG_W);
    send_line(2 * IMG_W);
    send_bytes(6);
    #2;
    check("pre_rst_wren", wren, 1'b1);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    last_addr = 0;
    last_data = 0;
    pix_idx   = 0;
    exp_ovr   = 1'b0;
    exp_lerr  = 1'b0;
    exp_fc    = 0;
    #1;
    check("midrst_wren", wren, 1'b0);
    check("midrst_addr", 32'(wraddress), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
`ifdef CAPTURE_STATS_EN
    check("midrst_fcount", frame_count, 32'd0);
`endif
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 8'($urandom));

    // Frame E: restart after a full sync
    start_frame();
    send_line(2 * IMG_W);
    check("restart_addr0", seen_a[0], 32'd0);
    end_frame(1'b0, 8'h00);

    repeat (4) drive(1'b1, 1'b0, 8'h00);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("fs_total", fs_seen, exp_fs);
    check("fe_total", fe_seen, exp_fe);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
